// File: rtl/diff_modulo_block.sv
// N-th order finite difference of folded ADC samples, re-folded with a centred modulo 2^L,
// buffered and released to the loop block as res/en strobes spaced at least N+1 cycles apart.
module diff_modulo_block #(
  parameter int N          = 2,
  parameter int IN_RES     = 12,
  parameter int OUT_RES    = 16,
  parameter int L          = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_en,
  input  logic signed [IN_RES-1:0]  in_y,
  output logic                      in_ready,
  output logic                      en,
  output logic signed [OUT_RES-1:0] res,
  output logic                      overflow,
  output logic                      warm
);

  localparam int DW = IN_RES + N;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int GW = $clog2(N + 1);

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [GW-1:0]             wcnt_q, wcnt_d;
  logic signed [DW-1:0]      p_q [N];
  logic signed [DW-1:0]      p_d [N];
  logic signed [DW-1:0]      d   [N];
  logic signed [L-1:0]       dn_low;
  logic signed [OUT_RES-1:0] r;

  logic signed [OUT_RES-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]             wptr_q, wptr_d;
  logic [PW-1:0]             rptr_q, rptr_d;
  logic [CW-1:0]             count_q, count_d;
  logic [GW-1:0]             gap_q, gap_d;
  logic                      en_q, en_d;
  logic signed [OUT_RES-1:0] res_q, res_d;
  logic                      overflow_q, overflow_d;
  logic                      warm_q, warm_d;

  logic accept, push, pop;

  // Handshake: a sample is taken at a rising edge when in_en=1 and in_ready=1;
  // in_ready depends only on the registered fill level, never on in_en.
  assign in_ready = (count_q < CW'(FIFO_DEPTH));
  assign accept   = in_en & in_ready;
  assign push     = accept & (state_q == RUN);
  assign pop      = (count_q != '0) && (gap_q == '0);

  always_comb begin
    d[0] = DW'(in_y);
    for (int k = 1; k < N; k++) begin
      d[k] = d[k-1] - p_q[k-1];
    end
    // Only the low L bits of d_N matter: the centred fold is their sign extension.
    dn_low = L'(d[N-1] - p_q[N-1]);
    r      = OUT_RES'(dn_low);
  end

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    gap_d      = gap_q;
    en_d       = 1'b0;
    res_d      = res_q;
    overflow_d = overflow_q;
    warm_d     = warm_q;
    for (int k = 0; k < N; k++) begin
      p_d[k] = p_q[k];
    end

    if (accept) begin
      for (int k = 0; k < N; k++) begin
        p_d[k] = d[k];
      end
      if (state_q == WARMUP) begin
        wcnt_d = wcnt_q + GW'(1);
        if (wcnt_q == GW'(N - 1)) begin
          state_d = RUN;
          warm_d  = 1'b1;
        end
      end
    end

    if (in_en && !in_ready) begin
      overflow_d = 1'b1;
    end

    if (pop) begin
      en_d   = 1'b1;
      res_d  = fifo_mem[rptr_q];
      rptr_d = rptr_q + PW'(1);
      gap_d  = GW'(N);
    end else if (gap_q != '0) begin
      gap_d = gap_q - GW'(1);
    end

    if (push) begin
      wptr_d = wptr_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A flush overrides any accept or pop happening at the same edge.
    if (flush) begin
      state_d    = WARMUP;
      wcnt_d     = '0;
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
      gap_d      = '0;
      en_d       = 1'b0;
      res_d      = '0;
      overflow_d = 1'b0;
      warm_d     = 1'b0;
      for (int k = 0; k < N; k++) begin
        p_d[k] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= WARMUP;
      wcnt_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      gap_q      <= '0;
      en_q       <= 1'b0;
      res_q      <= '0;
      overflow_q <= 1'b0;
      warm_q     <= 1'b0;
      for (int k = 0; k < N; k++) begin
        p_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      gap_q      <= gap_d;
      en_q       <= en_d;
      res_q      <= res_d;
      overflow_q <= overflow_d;
      warm_q     <= warm_d;
      for (int k = 0; k < N; k++) begin
        p_q[k] <= p_d[k];
      end
    end
  end

  // Storage needs no reset: count and pointers decide which entries are live.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      fifo_mem[wptr_q] <= r;
    end
  end

  assign en       = en_q;
  assign res      = res_q;
  assign overflow = overflow_q;
  assign warm     = warm_q;

endmodule
